gf2m_poly_reducer: RTL and testbench

- Digit-serial GF(2^M) reduction unit that sits directly downstream of the three-way Toom-Cook carryless multiplier.
- Takes the raw 2M-bit carryless product c and returns c mod P(x), where P(x) = x^M + POLY. Together the two blocks form a complete binary-field multiplier.
- Uses a valid/ready handshake on both sides so it can be placed behind the multiplier's registered output.

---
 rtl/gf2m_pkg.sv | 18 +
 rtl/gf2m_reduce_digit.sv | 32 +++
 rtl/gf2m_poly_reducer.sv | 102 ++++++++++
 tb/tb_gf2m_poly_reducer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^M) multiplier datapath: reducer FSM states,
// cycle-count helper and the default field polynomial shared with the golden model.
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } red_state_e;

  // Low 1024 coefficients of P(x); the x^1024 term is implicit.
  localparam logic [1023:0] DEFAULT_POLY = 1024'h425;

  function automatic int reduce_cycles(input int m, input int step);
    return m / step;
  endfunction

endpackage

// File: rtl/gf2m_reduce_digit.sv
// Combinational digit step: eliminates STEP high coefficients of rem, top-down,
// starting at bit 2M-1-cnt*STEP; later sub-steps see earlier XOR updates.
module gf2m_reduce_digit #(
  parameter int M    = 1024,
  parameter int STEP = 8,
  parameter int CW   = 7
) (
  input  logic [2*M-1:0] rem_i,
  input  logic [CW-1:0]  cnt_i,
  input  logic [M-1:0]   poly_i,
  output logic [2*M-1:0] rem_o
);

  localparam int IW = $clog2(2 * M);

  logic [2*M-1:0] r;
  logic [IW-1:0]  idx;

  always_comb begin
    r   = rem_i;
    idx = '0;
    for (int j = 0; j < STEP; j++) begin
      idx = IW'(2 * M - 1 - int'(cnt_i) * STEP - j);
      // Bit idx is cleared by the implicit x^M term; POLY lands on idx-1..idx-M.
      if (r[idx]) begin
        r[idx -: M+1] = r[idx -: M+1] ^ {1'b1, poly_i};
      end
    end
    rem_o = r;
  end

endmodule

// File: rtl/gf2m_poly_reducer.sv
// Digit-serial c mod P(x) for a 2M-bit carryless product, STEP bits per clock.
// Result appears M/STEP cycles after accept and is held in DONE until out_ready.
module gf2m_poly_reducer
  import gf2m_pkg::*;
#(
  parameter int           M    = 1024,
  parameter logic [M-1:0] POLY = M'(DEFAULT_POLY),
  parameter int           STEP = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] in_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_data,
  output logic           busy
);

  localparam int NCYC = reduce_cycles(M, STEP);
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (M % STEP != 0) begin : g_step_check
    $error("gf2m_poly_reducer: M must be a multiple of STEP");
  end

  red_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*M-1:0] rem_q, rem_d;
  logic [2*M-1:0] rem_step;
  logic [M-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;

  gf2m_reduce_digit #(
    .M    (M),
    .STEP (STEP),
    .CW   (CW)
  ) u_digit (
    .rem_i  (rem_q),
    .cnt_i  (cnt_q),
    .poly_i (POLY),
    .rem_o  (rem_step)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = in_prod;
          cnt_d   = '0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        rem_d = rem_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NCYC - 1)) begin
          // Result is registered on the same edge that enters DONE.
          state_d     = DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = rem_step[M-1:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf2m_poly_reducer.sv
// Directed bench for the reducer in the small AES field: M=8, P(x)=x^8+x^4+x^3+x+1, STEP=2.
module tb_gf2m_poly_reducer;

  localparam int M    = 8;
  localparam int STEP = 2;
  localparam int LAT  = M / STEP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_prod = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          busy;

  int errs   = 0;
  int checks = 0;

  gf2m_poly_reducer #(
    .M    (M),
    .POLY (8'h1B),
    .STEP (STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sum of x^i mod P over the set bits, with x^i built by repeated xtime.
  function automatic logic [7:0] ref_mod(input logic [15:0] p);
    logic [7:0] acc;
    logic [7:0] xp;
    acc = '0;
    xp  = 8'h01;
    for (int i = 0; i < 16; i++) begin
      if (p[i]) acc = acc ^ xp;
      xp = xp[7] ? ((xp << 1) ^ 8'h1B) : (xp << 1);
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers p, waits for the result, checks latency and value; leaves DONE unacknowledged.
  task automatic send_wait(input string tag, input logic [15:0] p, input logic [7:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check_eq({tag, "_rdy"}, in_ready, 1);
    in_prod  = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check_eq({tag, "_lat"}, n, LAT);
    check_eq({tag, "_dat"}, out_data, exp);
  endtask

  task automatic ack(input string tag, input logic [7:0] exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_vld_clr"}, out_valid, 0);
    check_eq({tag, "_rdy_back"}, in_ready, 1);
    check_eq({tag, "_dat_hold"}, out_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vp [6];
    logic [7:0]  ve [6];
    logic [7:0]  q_exp [$];
    int          acc_cyc [$];
    int          n_res;
    logic [15:0] pr;

    vp[0] = 16'h2B79; ve[0] = 8'hC1;
    vp[1] = 16'h2BF9; ve[1] = 8'h41;
    vp[2] = 16'h0100; ve[2] = 8'h1B;
    vp[3] = 16'h00FF; ve[3] = 8'hFF;
    vp[4] = 16'h0000; ve[4] = 8'h00;
    vp[5] = 16'h8000; ve[5] = 8'h2F;

    #2;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_in_ready", in_ready, 1);

    for (int k = 0; k < 6; k++) begin
      send_wait($sformatf("vec%0d", k), vp[k], ve[k]);
      check_eq($sformatf("vec%0d_busy", k), busy, 1);
      ack($sformatf("vec%0d", k), ve[k]);
    end

    // Stall in DONE while a second product is offered.
    send_wait("hold", 16'h2BF9, 8'h41);
    in_prod  = 16'h0100;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("hold_vld", out_valid, 1);
      check_eq("hold_dat", out_data, 8'h41);
      check_eq("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ack("hold", 8'h41);
    check_eq("hold_not_taken", busy, 0);

    // Asynchronous reset during the second REDUCE cycle.
    in_prod  = 16'h00FF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("abort_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_vld", out_valid, 0);
    check_eq("abort_dat", out_data, 0);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("abort_rdy_after", in_ready, 1);
    send_wait("after_abort", 16'h2BF9, 8'h41);
    ack("after_abort", 8'h41);

    // Back-to-back with out_ready tied high: accept spacing must be LAT+2.
    out_ready = 1'b1;
    pr        = 16'($urandom());
    in_prod   = pr;
    in_valid  = 1'b1;
    n_res     = 0;
    for (int c = 0; c < 40; c++) begin
      logic acc_now;
      logic res_now;
      acc_now = in_valid && in_ready;
      res_now = out_valid && out_ready;
      if (res_now) begin
        if (q_exp.size() == 0) begin
          check_eq("b2b_spurious", 1, 0);
        end else begin
          check_eq($sformatf("b2b_res%0d", n_res), out_data, q_exp.pop_front());
        end
        n_res++;
      end
      if (acc_now) begin
        q_exp.push_back(ref_mod(pr));
        if (acc_cyc.size() > 0) check_eq("b2b_spacing", c - acc_cyc[$], LAT + 2);
        acc_cyc.push_back(c);
      end
      tick();
      if (acc_now) begin
        pr      = 16'($urandom());
        in_prod = pr;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_accepts", acc_cyc.size(), 7);
    check_eq("b2b_results", n_res, acc_cyc.size() - q_exp.size());
    check_eq("b2b_pending_le1", q_exp.size() <= 1, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
